// File: rtl/core_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package core_fetch_pkg;

  localparam logic [31:0] CORE_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/core_fetch_fifo.sv
// Prefetch FIFO: power-of-two depth, flush clears occupancy, synchronous active-low reset.
module core_fetch_fifo #(
  parameter int  DEPTH   = 2,
  parameter type entry_t = logic [63:0]
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  entry_t                     wdata,
  output entry_t                     head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   cnt;
  logic               do_push;
  logic               do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(DEPTH));
  assign count   = cnt;
  assign head    = mem[rd_ptr];

  // Pointers are exactly PTR_W bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      cnt <= cnt + CNT_W'(1);
      else if (!do_push && do_pop) cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/core_fetch.sv
// Instruction fetch stage: single-outstanding memory requests feeding a prefetch FIFO.
// Optional same-cycle response bypass to the decoder: define CORE_FETCH_BYPASS_EN.
module core_fetch
  import core_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = CORE_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        arst_ni,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic        id_valid_o,
  output logic [31:0] instruction_o,
  output logic [31:0] id_pc_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_e     state;
  fetch_state_e     state_next;
  logic [31:0]      fetch_pc;
  logic [31:0]      req_pc;
  logic             discard;
  fetch_entry_t     head;
  fetch_entry_t     push_entry;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic             rsp_accept;
  logic             space;
  logic             granted;

  assign granted    = (state == REQ) && instr_gnt_i;
  assign rsp_accept = (state == WAIT) && instr_rvalid_i && !discard && !redirect_i;
  assign push_entry = '{instr: instr_rdata_i, pc: req_pc};
  assign pop        = !fifo_empty && !stall_i;

`ifdef CORE_FETCH_BYPASS_EN
  logic bypass;
  assign bypass        = rsp_accept && fifo_empty;
  assign id_valid_o    = !fifo_empty || bypass;
  assign instruction_o = bypass ? instr_rdata_i : head.instr;
  assign id_pc_o       = bypass ? req_pc : head.pc;
  assign push          = rsp_accept && !fifo_full && !(bypass && !stall_i);
`else
  assign id_valid_o    = !fifo_empty;
  assign instruction_o = head.instr;
  assign id_pc_o       = head.pc;
  assign push          = rsp_accept && !fifo_full;
`endif

  // Occupancy after this cycle; a request is only launched when this leaves a free slot.
  always_comb begin
    count_next = count;
    if (redirect_i)          count_next = '0;
    else if (push && !pop)   count_next = count + CNT_W'(1);
    else if (!push && pop)   count_next = count - CNT_W'(1);
  end

  assign space = (count_next < CNT_W'(FIFO_DEPTH));

  always_ff @(posedge clk_i) begin
    if (!arst_ni) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      discard  <= 1'b0;
    end else begin
      state <= state_next;
      if (redirect_i)   fetch_pc <= word_align(redirect_pc_i);
      else if (granted) fetch_pc <= fetch_pc + 32'd4;
      if ((state == WAIT) && instr_rvalid_i)                  discard <= 1'b0;
      else if (redirect_i && (granted || (state == WAIT)))    discard <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (granted) req_pc <= fetch_pc;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (space) state_next = REQ;
      REQ:     if (instr_gnt_i) state_next = WAIT;
      WAIT:    if (instr_rvalid_i) state_next = space ? REQ : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    instr_req_o = (state == REQ);
  end

  assign instr_addr_o = fetch_pc;

  core_fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (arst_ni),
    .push  (push),
    .pop   (pop),
    .flush (redirect_i),
    .wdata (push_entry),
    .head  (head),
    .count (count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_core_fetch.sv
// Scoreboard bench for core_fetch: memory model, decoder model and directed plus random scenarios.
module tb_core_fetch;
  import core_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        arst_ni = 1'b0;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        stall_i = 1'b0;
  logic        id_valid_o;
  logic [31:0] instruction_o;
  logic [31:0] id_pc_o;

  always #5 clk = ~clk;

  core_fetch dut (
    .clk_i          (clk),
    .arst_ni        (arst_ni),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .stall_i        (stall_i),
    .id_valid_o     (id_valid_o),
    .instruction_o  (instruction_o),
    .id_pc_o        (id_pc_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard and memory model state
  fetch_entry_t q[$];
  logic [31:0]  exp_fetch_pc = CORE_RESET_PC;
  logic [31:0]  out_pc = '0;
  bit           outstanding = 0;
  bit           out_discard = 0;
  int           rdelay_cnt = 0;
  int           n_pops = 0;
  int           n_pushes = 0;

  // Stimulus knobs
  logic        rst_k = 1'b0;
  bit          stall_k = 0;
  bit          redir_k = 0;
  bit          stale_k = 0;
  logic [31:0] redir_pc_k = '0;
  int          gnt_hold = 0;
  int          rdelay_k = 1;

  // Observed outputs of the last cycle
  logic        obs_req, obs_valid;
  logic [31:0] obs_addr, obs_instr, obs_pc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : (NOP_INSTR | (a << 12));
  endfunction

  task automatic cycle();
    fetch_entry_t e;
    bit           resp_now;
    bit           gnt_now;
    logic [31:0]  tgt;
    @(negedge clk);
    obs_req   = instr_req_o;
    obs_addr  = instr_addr_o;
    obs_valid = id_valid_o;
    obs_instr = instruction_o;
    obs_pc    = id_pc_o;
    if (!arst_ni) begin
      check_eq("rst_req", 32'(obs_req), 32'd0);
      check_eq("rst_addr", obs_addr, CORE_RESET_PC);
      check_eq("rst_valid", 32'(obs_valid), 32'd0);
      check_eq("rst_instr", obs_instr, 32'd0);
      check_eq("rst_pc", obs_pc, 32'd0);
    end else begin
      check_eq("valid", 32'(obs_valid), 32'(q.size() != 0));
      if (obs_valid && q.size() != 0) begin
        check_eq("instr", obs_instr, q[0].instr);
        check_eq("pc", obs_pc, q[0].pc);
      end
      if (obs_valid && !stall_k) begin
        n_pops++;
        if (q.size() != 0) void'(q.pop_front());
      end
      if (obs_req) begin
        check_eq("req_addr", obs_addr, exp_fetch_pc);
        check_eq("one_outstanding", 32'(outstanding), 32'd0);
      end
    end

    resp_now = outstanding && (rdelay_cnt == 0);
    gnt_now  = 0;
    if (obs_req && arst_ni && rst_k) begin
      if (gnt_hold > 0) gnt_hold--;
      else gnt_now = 1;
    end
    tgt = {redir_pc_k[31:2], 2'b00};

    instr_gnt_i    = gnt_now;
    instr_rvalid_i = resp_now || stale_k;
    instr_rdata_i  = resp_now ? mem_word(out_pc) : 32'hDEAD_BEEF;
    redirect_i     = redir_k;
    redirect_pc_i  = redir_pc_k;
    stall_i        = stall_k;
    arst_ni        = rst_k;

    if (!rst_k) begin
      q.delete();
      exp_fetch_pc = CORE_RESET_PC;
      outstanding  = 0;
      out_discard  = 0;
    end else begin
      if (redir_k) q.delete();
      if (resp_now) begin
        if (!out_discard && !redir_k) begin
          e.instr = mem_word(out_pc);
          e.pc    = out_pc;
          q.push_back(e);
          n_pushes++;
        end
        outstanding = 0;
      end else if (outstanding) begin
        rdelay_cnt--;
        if (redir_k) out_discard = 1;
      end
      if (gnt_now) begin
        outstanding  = 1;
        out_pc       = exp_fetch_pc;
        out_discard  = redir_k;
        rdelay_cnt   = rdelay_k - 1;
        exp_fetch_pc = redir_k ? tgt : exp_fetch_pc + 32'd4;
      end else if (redir_k) begin
        exp_fetch_pc = tgt;
      end
    end
    redir_k = 0;
  endtask

  task automatic do_reset();
    rst_k = 1'b0;
    cycle();
    rst_k = 1'b1;
    cycle();
  endtask

  initial begin
    int po, pu;

    // Basic fetch with zero-wait memory
    do_reset();
    cycle();
    check_eq("s1_req", 32'(obs_req), 32'd1);
    check_eq("s1_addr", obs_addr, 32'h0);
    cycle();
    cycle();
    check_eq("s1_valid", 32'(obs_valid), 32'd1);
    check_eq("s1_instr", obs_instr, 32'h0050_0093);
    check_eq("s1_pc", obs_pc, 32'h0);
    check_eq("s1_next_req", 32'(obs_req), 32'd1);
    check_eq("s1_next_addr", obs_addr, 32'h4);
    repeat (10) cycle();

    // Decoder stall fills the FIFO and stops requests
    stall_k = 1;
    do_reset();
    repeat (10) cycle();
    check_eq("s2_req_off", 32'(obs_req), 32'd0);
    check_eq("s2_valid", 32'(obs_valid), 32'd1);
    check_eq("s2_head", obs_pc, 32'h0);
    stall_k = 0;
    cycle();
    check_eq("s2_pop0", obs_pc, 32'h0);
    cycle();
    check_eq("s2_pop1", obs_pc, 32'h4);
    cycle();
    cycle();
    check_eq("s2_pop2_valid", 32'(obs_valid), 32'd1);
    check_eq("s2_pop2", obs_pc, 32'h8);

    // Redirect while waiting; late response must be dropped
    rdelay_k = 4;
    do_reset();
    cycle();
    rdelay_k = 1;
    redir_k = 1;
    redir_pc_k = 32'h0000_0103;
    cycle();
    repeat (3) cycle();
    check_eq("s3_drop_valid", 32'(obs_valid), 32'd0);
    cycle();
    check_eq("s3_req", 32'(obs_req), 32'd1);
    check_eq("s3_addr", obs_addr, 32'h100);
    cycle();
    cycle();
    check_eq("s3_valid", 32'(obs_valid), 32'd1);
    check_eq("s3_pc", obs_pc, 32'h100);

    // Redirect coinciding with rvalid while one entry is buffered
    stall_k = 1;
    do_reset();
    repeat (3) cycle();
    redir_k = 1;
    redir_pc_k = 32'h0000_0200;
    cycle();
    check_eq("s4_had_entry", 32'(obs_valid), 32'd1);
    stall_k = 0;
    cycle();
    check_eq("s4_flushed", 32'(obs_valid), 32'd0);
    check_eq("s4_req", 32'(obs_req), 32'd1);
    check_eq("s4_addr", obs_addr, 32'h200);
    repeat (4) cycle();

    // Reset in the middle of a transaction, then a stale response
    rdelay_k = 3;
    do_reset();
    cycle();
    cycle();
    rst_k = 1'b0;
    cycle();
    rst_k = 1'b1;
    stale_k = 1;
    gnt_hold = 1;
    cycle();
    check_eq("s5_rst_instr", obs_instr, 32'h0);
    cycle();
    check_eq("s5_req", 32'(obs_req), 32'd1);
    check_eq("s5_addr", obs_addr, CORE_RESET_PC);
    stale_k = 0;
    rdelay_k = 1;
    cycle();
    cycle();
    cycle();
    check_eq("s5_valid", 32'(obs_valid), 32'd1);
    check_eq("s5_instr", obs_instr, 32'h0050_0093);
    check_eq("s5_pc", obs_pc, 32'h0);

    // Grant withheld: request must hold steady, one response per grant
    do_reset();
    po = n_pops;
    pu = n_pushes;
    gnt_hold = 5;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_eq("s6_req_hold", 32'(obs_req), 32'd1);
      check_eq("s6_addr_hold", obs_addr, 32'h0);
    end
    repeat (20) cycle();
    gnt_hold = 1000;
    repeat (6) cycle();
    check_eq("s6_one_per_grant", 32'(n_pops - po), 32'(n_pushes - pu));
    check_eq("s6_drained", 32'(obs_valid), 32'd0);
    gnt_hold = 0;

    // Address wrap at the top of the address space
    redir_k = 1;
    redir_pc_k = 32'hFFFF_FFFE;
    cycle();
    repeat (8) cycle();

    // Random stall, memory latency, grant delay and redirects
    for (int i = 0; i < 400; i++) begin
      stall_k  = ($urandom_range(0, 9) < 3);
      rdelay_k = $urandom_range(1, 3);
      if (gnt_hold == 0 && $urandom_range(0, 3) == 0) gnt_hold = $urandom_range(1, 3);
      if ($urandom_range(0, 29) == 0) begin
        redir_k = 1;
        redir_pc_k = $urandom;
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/core_fetch.md
Name: core_fetch

Overview:
- Instruction fetch stage, directly upstream of the decoder.
- Issues word requests to instruction memory over a req/gnt/rvalid handshake, with at most one request outstanding.
- Buffers returned words with their PCs in a small prefetch FIFO and presents the FIFO head to the decoder (instruction, PC, valid). The decoder stage throttles it with stall_i.
- Accepts a branch/jump redirect that flushes the FIFO and discards any in-flight response.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
FIFO_DEPTH, 2, prefetch entries; power of two, >= 2

Ports:
clk_i  input  1  clock
arst_ni  input  1  reset, synchronous, active-low; sampled on rising clk_i only
instr_req_o  output  1  fetch request
instr_addr_o  output  32  fetch word address; [1:0] always 0
instr_gnt_i  input  1  request accepted this cycle
instr_rvalid_i  input  1  response data valid
instr_rdata_i  input  32  response instruction word
redirect_i  input  1  control-flow change, single-cycle pulse
redirect_pc_i  input  32  redirect target; [1:0] ignored
stall_i  input  1  decode stage cannot accept this cycle
id_valid_o  output  1  instruction_o/id_pc_o hold a valid instruction
instruction_o  output  32  instruction to decoder
id_pc_o  output  32  PC of instruction_o

Behaviour:
- Reset (arst_ni=0 at clk edge) sets:
  - state=IDLE, fetch_pc=RESET_PC, FIFO empty, discard=0, all FIFO entries 0.
  - Outputs: instr_req_o=0, instr_addr_o=RESET_PC, id_valid_o=0, instruction_o=0, id_pc_o=0.
- FSM states:
  - IDLE: instr_req_o=0. Moves to REQ when FIFO count (after this cycle's pop) < FIFO_DEPTH.
  - REQ: instr_req_o=1, instr_addr_o=fetch_pc. On instr_gnt_i, moves to WAIT and fetch_pc += 4 (wraps mod 2^32). Otherwise stays in REQ.
  - WAIT: waits for instr_rvalid_i.
    - Pushes {instr_rdata_i, pc of request} unless discard=1.
    - On rvalid, clears discard and goes to REQ if there is space, else IDLE.
- Slot reservation: a request is only issued when a FIFO slot is free. Only rvalid pushes, so the slot stays reserved through REQ/WAIT, and a push can never find the FIFO full.
- instr_rvalid_i outside WAIT is ignored. This covers late responses after a mid-transaction reset.
- Latency:
  - First instr_req_o in the cycle after reset release.
  - A pushed entry is visible (id_valid_o=1) the cycle after rvalid.
  - With 0-wait-state memory (gnt same cycle, rvalid next), steady-state throughput is 1 instruction per 2 cycles.
- Decoder side:
  - id_valid_o = FIFO not empty; instruction_o/id_pc_o = head entry.
  - Pop when id_valid_o && !stall_i.
  - Head is held stable while stall_i=1.
- Redirect (highest priority):
  - Flushes the FIFO: id_valid_o=0 the next cycle, including the head being consumed that cycle.
  - Sets fetch_pc={redirect_pc_i[31:2],2'b00}.
  - In REQ without gnt: request retracted. The next cycle is REQ at the target address; the memory protocol permits retraction.
  - In REQ with gnt in the same cycle: go to WAIT with discard=1.
  - In WAIT without rvalid: stay in WAIT with discard=1.
  - In WAIT with rvalid in the same cycle: data dropped, next state REQ.
  - In IDLE: next state REQ.
- Simultaneous push and pop: count unchanged; FIFO pointers wrap mod FIFO_DEPTH.

Optional Feature:
- Macro CORE_FETCH_BYPASS_EN.
- Defined:
  - When the FIFO is empty and an accepted (non-discarded) rvalid arrives, id_valid_o/instruction_o/id_pc_o are driven combinationally from the response in the same cycle.
  - If !stall_i, the word is consumed and not pushed; otherwise it is pushed.
  - A redirect in that cycle suppresses the bypass.
  - Throughput is 1 instruction/cycle only if the memory pipelines requests; single-outstanding still holds.
- Undefined: no combinational path from instr_* to id_* outputs; behaviour exactly as above.

Decomposition:
- core_pkg additions: fetch_entry_t {instr[31:0], pc[31:0]}, fetch_state_e {IDLE, REQ, WAIT}, CORE_RESET_PC constant (default for RESET_PC), NOP_INSTR 32'h0000_0013 for bench use.
- Sub-module core_fetch_fifo:
  - Parameterised by depth and entry type.
  - Ports: push/pop/flush, head, count, empty, full; sync active-low reset.
  - FSM, PC and discard logic stay in core_fetch.

Test Plan:
- Reset release, memory gnt same cycle, rvalid next, rdata=32'h00500093, stall_i=0:
  - instr_req_o=1 with addr 0x0 at cycle 1.
  - id_valid_o=1, instruction_o=32'h00500093, id_pc_o=0x0 at cycle 3.
  - Next request addr=0x4.
- stall_i=1 held 10 cycles:
  - FIFO fills to 2 (PCs 0x0, 0x4) and instr_req_o drops to 0.
  - Head stays PC 0x0.
  - Release stall: head advances to 0x4, then 0x8, in order.
- redirect_i with redirect_pc_i=0x103 while in WAIT; rvalid arrives 3 cycles later:
  - Response dropped.
  - Next request addr=0x100.
  - First delivered id_pc_o=0x100.
- redirect_i in the same cycle as rvalid, FIFO holding one entry:
  - Both entry and response discarded; id_valid_o=0 next cycle.
  - instr_req_o=1 addr=target the following cycle.
- Assert arst_ni=0 for one cycle during WAIT, then deliver a stale rvalid:
  - Stale rvalid ignored.
  - Outputs at reset values.
  - Fetch restarts at RESET_PC.
- gnt withheld 5 cycles:
  - instr_req_o and instr_addr_o held stable.
  - Exactly one response pushed per grant.
